// File: rtl/alu_result_if.sv
// Handshake bundle between the ALU, the result stage and writeback.
// The slave side is the result stage; the master side is its environment
// (ALU driving the input half, writeback driving out_ready).
interface alu_result_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_overflow;
    logic              in_negative;
    logic              in_zero;
    logic [RD_W-1:0]   in_rd;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic [2:0]        out_flags;

    modport master (
        output in_valid, in_result, in_overflow, in_negative, in_zero, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_flags
    );

    modport slave (
        input  in_valid, in_result, in_overflow, in_negative, in_zero, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_flags
    );
endinterface

// File: rtl/alu_result_stage.sv
// Execute/writeback stage behind the 32-bit ALU: a 2-entry in-order skid
// FIFO holding {result, rd, V, N, Z}, plus committed-flags, sticky overflow
// and a saturating overflow event counter updated as entries retire.
module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_if.slave      bus,
    input  logic             flush,
    input  logic             clear_status,
    output logic [2:0]       commit_flags,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_count
);
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic [2:0]        flags;   // {V,N,Z}
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    entry_t           mem [2];
    entry_t           head;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] ovf_base;

    // NOTE: handshake outputs come only from the registered count, so
    // in_ready never forms a combinational path from out_ready.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);

    assign push = bus.in_valid  & bus.in_ready  & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    assign head           = mem[rd_ptr];
    assign bus.out_result = head.result;
    assign bus.out_rd     = head.rd;
    assign bus.out_flags  = head.flags;

    // Counter value the pop increments from: clear_status applies first.
    always_comb begin
        ovf_base = clear_status ? '0 : ovf_count;
    end

    // Entry storage: write the incoming ALU result at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset (only two entries) so out_* read zero
            // straight out of reset instead of X.
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{result: bus.in_result, rd: bus.in_rd,
                             flags: {bus.in_overflow, bus.in_negative, bus.in_zero}};
        end
    end

    // Pointers and occupancy; flush empties the FIFO and ignores push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Status registers: retire-time flag capture, sticky overflow, counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_flags <= 3'b000;
            sticky_ovf   <= 1'b0;
            ovf_count    <= '0;
        end else begin
            if (pop) commit_flags <= head.flags;
            if (pop && head.flags[2]) begin
                sticky_ovf <= 1'b1;
                ovf_count  <= (ovf_base == CNT_MAX) ? ovf_base : ovf_base + CNT_ONE;
            end else if (clear_status) begin
                sticky_ovf <= 1'b0;
                ovf_count  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage. The stimulus process queues each
// accepted entry; a negedge monitor compares the DUT head, handshake and
// status outputs against a queue-based reference and retires entries.
module tb_alu_result_stage;
    localparam int DATA_W  = 32;
    localparam int RD_W    = 5;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic [2:0]        flags;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             clear_status = 1'b0;
    logic [2:0]       commit_flags;
    logic             sticky_ovf;
    logic [CNT_W-1:0] ovf_count;

    alu_result_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

    alu_result_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flush        (flush),
        .clear_status (clear_status),
        .commit_flags (commit_flags),
        .sticky_ovf   (sticky_ovf),
        .ovf_count    (ovf_count)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    bit   pend = 1'b0;
    exp_t pend_e;
    exp_t mon_e;
    logic [2:0] m_commit = 3'b000;
    bit   m_sticky = 1'b0;
    int   m_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus: commit last cycle's accepted entry to the
    // scoreboard at the edge, then drive new inputs just after it.
    task automatic step(input bit vi, input bit ordy, input bit fl, input bit clr,
                        input logic [31:0] res, input logic [2:0] flg, input logic [4:0] rd);
        @(posedge clk);
        if (pend) exp_q.push_back(pend_e);
        pend = 1'b0;
        #1;
        bus.in_valid    = vi;
        bus.out_ready   = ordy;
        bus.in_result   = res;
        bus.in_overflow = flg[2];
        bus.in_negative = flg[1];
        bus.in_zero     = flg[0];
        bus.in_rd       = rd;
        flush           = fl;
        clear_status    = clr;
        pend            = vi && rst_n && !fl && (exp_q.size() < 2);
        pend_e          = '{result: res, rd: rd, flags: flg};
    endtask

    task automatic idle(input bit ordy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, ordy, 1'b0, 1'b0, $urandom, 3'($urandom), 5'($urandom));
    endtask

    // Monitor: compare at the falling edge, then retire per the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_commit = 3'b000;
                m_sticky = 1'b0;
                m_cnt    = 0;
            end
            check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
            check("commit_flags", 64'(commit_flags), 64'(m_commit));
            check("sticky_ovf", 64'(sticky_ovf), 64'(m_sticky));
            check("ovf_count", 64'(ovf_count), 64'(m_cnt));
            if (exp_q.size() != 0) begin
                check("out_result", 64'(bus.out_result), 64'(exp_q[0].result));
                check("out_rd", 64'(bus.out_rd), 64'(exp_q[0].rd));
                check("out_flags", 64'(bus.out_flags), 64'(exp_q[0].flags));
            end
            if (rst_n) begin
                if (clear_status) begin
                    m_sticky = 1'b0;
                    m_cnt    = 0;
                end
                if (flush) begin
                    exp_q.delete();
                end else if (exp_q.size() != 0 && bus.out_ready) begin
                    mon_e    = exp_q.pop_front();
                    m_commit = mon_e.flags;
                    if (mon_e.flags[2]) begin
                        m_sticky = 1'b1;
                        if (m_cnt < CNT_MAX) m_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        // Reset held with a valid ALU result presented.
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b1;
        bus.in_result   = 32'hCAFE_0001;
        bus.in_overflow = 1'b0;
        bus.in_negative = 1'b1;
        bus.in_zero     = 1'b0;
        bus.in_rd       = 5'd7;
        repeat (3) @(negedge clk);
        #2;
        rst_n  = 1'b1;
        pend   = 1'b1;
        pend_e = '{result: 32'hCAFE_0001, rd: 5'd7, flags: 3'b010};

        // Streaming with writeback always ready.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 3'b000, 5'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 3'b010, 5'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 3'b001, 5'd3);
        idle(1'b1, 2);

        // Backpressure: A, B fill the FIFO, C waits upstream until accepted.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hAAAA_0000, 3'b010, 5'd10);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hBBBB_0000, 3'b000, 5'd11);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hCCCC_0000, 3'b001, 5'd12);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hCCCC_0000, 3'b001, 5'd12);
        for (int i = 0; i < 8 && !pend; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'hCCCC_0000, 3'b001, 5'd12);
        check("c_accepted", 64'(pend), 64'(1));
        idle(1'b1, 4);

        // Overflow counter saturation, then clear alone, then clear with a V=1 pop.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, $urandom, 3'b100, 5'(i));
        idle(1'b1, 3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 3'b000, 5'd0);
        idle(1'b1, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b110, 5'd20);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 3'b000, 5'd21);
        idle(1'b0, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 3'b000, 5'd0);
        idle(1'b1, 3);

        // Flush with both entries buffered and a push and pop offered.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0F0F_0F0F, 3'b100, 5'd30);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hF0F0_F0F0, 3'b101, 5'd31);
        idle(1'b0, 1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h5555_5555, 3'b100, 5'd29);
        idle(1'b1, 2);

        // Asynchronous reset between edges with two entries buffered.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 3'b100, 5'd4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h2222_2222, 3'b010, 5'd5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 5'd0);
        #2;
        rst_n = 1'b0;
        pend  = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("async_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("async_rst_ovf_count", 64'(ovf_count), 64'(0));
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0,
                 $urandom, 3'($urandom), 5'($urandom));
        idle(1'b1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
